// File: rtl/budget_response_arbiter.sv
// Round-robin arbiter over a refillable grant budget.
// Requests left waiting too long latch a sticky fault.
module budget_response_arbiter #(
    parameter int NREQ     = 2,
    parameter int BUDGET   = 2,
    parameter int MAX_WAIT = 3,
    parameter int CW       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic            refill,
    output logic [NREQ-1:0] grant,
    output logic [CW-1:0]   budget_left,
    output logic            error,
    output logic            _rt_get
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_EXH   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [CW-1:0]   budget_q, budget_d;
    logic            err_q, err_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   wait_q [NREQ];
    logic [CW-1:0]   wait_d [NREQ];

    logic            found;
    logic [PW-1:0]   win;
    int              idx;

    // First active requester at or after the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        grant_d  = '0;
        budget_d = budget_q;
        err_d    = err_q;
        ptr_d    = ptr_q;
        state_d  = state_q;
        for (int i = 0; i < NREQ; i++) begin
            wait_d[i] = wait_q[i];
        end

        if (state_q == S_FAULT) begin
            if (refill) begin
                budget_d = CW'(BUDGET);
            end
        end else begin
            if (refill) begin
                budget_d = CW'(BUDGET);
            end else if (enable && budget_q != '0 && found) begin
                grant_d[win] = 1'b1;
                budget_d     = budget_q - 1'b1;
                if (win == PW'(NREQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win + 1'b1;
                end
            end

            // A grant at this edge beats a timeout on the same requester.
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || grant_d[i]) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] < CW'(MAX_WAIT)) begin
                    wait_d[i] = wait_q[i] + 1'b1;
                end
                if (wait_d[i] == CW'(MAX_WAIT)) begin
                    err_d = 1'b1;
                end
            end

            if (err_d) begin
                state_d = S_FAULT;
            end else if (budget_d == '0) begin
                state_d = S_EXH;
            end else if (|req) begin
                state_d = S_SERVE;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            budget_q <= CW'(BUDGET);
            err_q    <= 1'b0;
            ptr_q    <= '0;
            for (int i = 0; i < NREQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            budget_q <= budget_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
            for (int i = 0; i < NREQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign grant       = grant_q;
    assign budget_left = budget_q;
    assign error       = err_q;
    assign _rt_get     = |req;

endmodule
